// File: rtl/ysyx_23060171_mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide controller.
// Contents:
//   MDU_XLEN    - operand/result width (only 32 is supported)
//   mdu_op_e    - RV32M funct3 encoding of the eight M-extension ops
//   mdu_state_e - controller FSM states
package ysyx_23060171_mdu_pkg;

    localparam int unsigned MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mdu_state_e;

endpackage

// File: rtl/ysyx_23060171_mdu_step.sv
// One iteration of the iterative multiply/divide datapath (purely combinational).
// Ports:
//   is_div  in  1    1: restoring shift-subtract step, 0: shift-add step
//   hi      in  W+1  multiply: upper partial product; divide: partial remainder
//   lo      in  W    multiply: lower product / remaining multiplier bits;
//                    divide: remaining dividend bits / collected quotient bits
//   opnd    in  W    multiplicand or divisor magnitude
//   hi_next out W+1  updated hi
//   lo_next out W    updated lo
module ysyx_23060171_mdu_step
    import ysyx_23060171_mdu_pkg::*;
#(
    parameter int unsigned W = MDU_XLEN
) (
    input  logic         is_div,
    input  logic [W:0]   hi,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] opnd,
    output logic [W:0]   hi_next,
    output logic [W-1:0] lo_next
);

    logic [W:0]   sum;
    logic [W:0]   shifted;
    logic [W+1:0] diff;

    always_comb begin
        // Multiply: conditionally add multiplicand, then shift {hi,lo} right.
        sum     = lo[0] ? (hi + {1'b0, opnd}) : hi;
        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // The extra top bit of diff is the borrow that decides restore.
        shifted = {hi[W-1:0], lo[W-1]};
        diff    = {1'b0, shifted} - {2'b00, opnd};

        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            if (!diff[W+1]) begin
                hi_next = diff[W:0];
                lo_next = {lo[W-2:0], 1'b1};
            end else begin
                hi_next = shifted;
                lo_next = {lo[W-2:0], 1'b0};
            end
        end else begin
            hi_next = {1'b0, sum[W:1]};
            lo_next = {sum[0], lo[W-1:1]};
        end
    end

endmodule

// File: rtl/ysyx_23060171_mdu_ctrl.sv
// Iterative RV32M multiply/divide controller: 32 unsigned iterations on operand
// magnitudes with sign correction at the end, plus a one-cycle path for
// divide-by-zero and signed-overflow divides.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (ready only when idle)
//   op, a, b            RV32M op (funct3 encoding) and operands rs1/rs2
//   flush               abandon any in-flight operation
//   out_valid/out_ready result handshake
//   result              operation result, forced to 0 while out_valid is low
module ysyx_23060171_mdu_ctrl
    import ysyx_23060171_mdu_pkg::*;
#(
    parameter int unsigned XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [4:0]      CNT_LAST = 5'(XLEN - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_next;
    mdu_op_e           op_in, op_q;
    logic [4:0]        cnt;
    logic [XLEN:0]     hi, hi_next;
    logic [XLEN-1:0]   lo, lo_next, opnd, res_q;
    logic              neg;

    logic              accept, step_en;
    logic              a_neg, b_neg, neg_in, is_div_in, quo_in, fast_hit;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res;
    logic              step_div;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    assign op_in = mdu_op_e'(op);

    // Request decode: magnitudes, result sign and the fast-path check.
    always_comb begin
        a_neg     = a[XLEN-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_neg     = b[XLEN-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else the product/quotient sign.
        neg_in    = (op_in inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
        is_div_in = op_in inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
        quo_in    = op_in inside {OP_DIV, OP_DIVU};
        fast_hit  = is_div_in && ((b == '0) ||
                    ((op_in inside {OP_DIV, OP_REM}) && (a == INT_MIN) && (b == '1)));
        if (b == '0) begin
            fast_res = quo_in ? '1 : a;
        end else begin
            fast_res = quo_in ? INT_MIN : '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and handshake outputs; flush wins over both handshakes.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        step_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = fast_hit ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (flush || out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign step_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

    ysyx_23060171_mdu_step #(
        .W (XLEN)
    ) u_step (
        .is_div  (step_div),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign correction and result select, taken from the final step's outputs
    // so the result register is loaded on the same edge that enters DONE.
    always_comb begin
        prod      = {hi_next[XLEN-1:0], lo_next};
        prod_s    = neg ? -prod : prod;
        quo_s     = neg ? -lo_next : lo_next;
        rem_s     = neg ? -hi_next[XLEN-1:0] : hi_next[XLEN-1:0];
        final_res = '0;
        case (op_q)
            OP_MUL:                       final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = quo_s;
            OP_REM, OP_REMU:              final_res = rem_s;
            default:                      final_res = '0;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= OP_MUL;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            neg   <= 1'b0;
            res_q <= '0;
        end else if (accept) begin
            op_q <= op_in;
            cnt  <= '0;
            hi   <= '0;
            lo   <= a_mag;
            opnd <= b_mag;
            neg  <= neg_in;
            if (fast_hit) begin
                res_q <= fast_res;
            end
        end else if (step_en) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 5'd1;
            if (cnt == CNT_LAST) begin
                res_q <= final_res;
            end
        end
    end

    assign result = out_valid ? res_q : '0;

endmodule
